// File: rtl/cacode_acq_correlator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cacode_acq_correlator                                                      |
// | Serial code-phase search: correlates a 1-bit chip stream against a local   |
// | C/A Gold code, one 1023-chip epoch per candidate phase, one-chip slips.    |
// | Optional: CACODE_ACQ_EARLY_EXIT_EN stops at the first epoch >= threshold.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module cacode_acq_correlator #(
    parameter int NUM_PHASES = 1023,
    parameter int CORR_W     = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [5:0]               prn_num,
    input  logic [10:0]              threshold,
    input  logic                     start,
    input  logic                     chip_in,
    input  logic                     chip_in_valid,
    output logic                     chip_in_ready,
    output logic                     busy,
    output logic                     corr_valid,
    output logic signed [CORR_W-1:0] corr_value,
    output logic                     acq_done,
    output logic                     acq_found,
    output logic [9:0]               code_phase,
    output logic [10:0]              peak_value
);
    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_CORR = 3'd1;
    localparam logic [2:0] c_DUMP = 3'd2;
    localparam logic [2:0] c_SLIP = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    localparam logic [9:0] c_LAST_CHIP  = 10'd1022;
    localparam logic [9:0] c_LAST_PHASE = 10'(NUM_PHASES - 1);

    logic [2:0]               r_state;
    logic [9:0]               r_g1;
    logic [9:0]               r_g2;
    logic [3:0]               r_tap_a;
    logic [3:0]               r_tap_b;
    logic [10:0]              r_threshold;
    logic signed [CORR_W-1:0] r_acc;
    logic [9:0]               r_chip_cnt;
    logic [9:0]               r_phase;
    logic [10:0]              r_peak;
    logic [9:0]               r_code_phase;
    logic signed [CORR_W-1:0] r_corr_value;
    logic                     r_acq_done;
    logic                     r_acq_found;

    logic [7:0]               w_taps;
    logic                     w_prn_ok;
    logic [9:0]               w_g1_next;
    logic [9:0]               w_g2_next;
    logic                     w_local_chip;
    logic                     w_accept;
    logic signed [CORR_W-1:0] w_step;
    logic signed [CORR_W-1:0] w_acc_next;
    logic signed [CORR_W-1:0] w_abs;
    logic [10:0]              w_mag;
    logic                     w_early;
    logic                     w_update;
    logic [10:0]              w_peak_next;

    // G2 phase-select stage pair per PRN, one stage number (1..10) per nibble
    always_comb begin
        w_taps = 8'h00;
        case (prn_num)
            6'd1:  w_taps = 8'h26;  6'd2:  w_taps = 8'h37;  6'd3:  w_taps = 8'h48;
            6'd4:  w_taps = 8'h59;  6'd5:  w_taps = 8'h19;  6'd6:  w_taps = 8'h2A;
            6'd7:  w_taps = 8'h18;  6'd8:  w_taps = 8'h29;  6'd9:  w_taps = 8'h3A;
            6'd10: w_taps = 8'h23;  6'd11: w_taps = 8'h34;  6'd12: w_taps = 8'h56;
            6'd13: w_taps = 8'h67;  6'd14: w_taps = 8'h78;  6'd15: w_taps = 8'h89;
            6'd16: w_taps = 8'h9A;  6'd17: w_taps = 8'h14;  6'd18: w_taps = 8'h25;
            6'd19: w_taps = 8'h36;  6'd20: w_taps = 8'h47;  6'd21: w_taps = 8'h58;
            6'd22: w_taps = 8'h69;  6'd23: w_taps = 8'h13;  6'd24: w_taps = 8'h46;
            6'd25: w_taps = 8'h57;  6'd26: w_taps = 8'h68;  6'd27: w_taps = 8'h79;
            6'd28: w_taps = 8'h8A;  6'd29: w_taps = 8'h16;  6'd30: w_taps = 8'h27;
            6'd31: w_taps = 8'h38;  6'd32: w_taps = 8'h49;  6'd33: w_taps = 8'h5A;
            6'd34: w_taps = 8'h4A;  6'd35: w_taps = 8'h17;  6'd36: w_taps = 8'h28;
            6'd37: w_taps = 8'h4A;
            default: w_taps = 8'h00;
        endcase
    end

    assign w_prn_ok = (w_taps != 8'h00);

    // Stage n of each register lives in bit n-1; new bits enter stage 1
    assign w_g1_next    = {r_g1[8:0], r_g1[2] ^ r_g1[9]};
    assign w_g2_next    = {r_g2[8:0], r_g2[1] ^ r_g2[2] ^ r_g2[5] ^ r_g2[7] ^ r_g2[8] ^ r_g2[9]};
    assign w_local_chip = r_g1[9] ^ r_g2[r_tap_a] ^ r_g2[r_tap_b];

    assign chip_in_ready = (r_state == c_CORR);
    assign w_accept      = chip_in_valid && chip_in_ready;
    assign w_step        = (chip_in == w_local_chip) ? CORR_W'(1) : {CORR_W{1'b1}};
    assign w_acc_next    = r_acc + w_step;

    assign w_abs = r_acc[CORR_W-1] ? -r_acc : r_acc;
    assign w_mag = 11'(w_abs);

`ifdef CACODE_ACQ_EARLY_EXIT_EN
    assign w_early = (w_mag >= r_threshold);
`else
    assign w_early = 1'b0;
`endif

    // Strict compare keeps the earliest phase on ties
    assign w_update    = (w_mag > r_peak) || w_early;
    assign w_peak_next = w_update ? w_mag : r_peak;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_g1         <= 10'h3FF;
            r_g2         <= 10'h3FF;
            r_tap_a      <= 4'd0;
            r_tap_b      <= 4'd0;
            r_threshold  <= 11'd0;
            r_acc        <= '0;
            r_chip_cnt   <= 10'd0;
            r_phase      <= 10'd0;
            r_peak       <= 11'd0;
            r_code_phase <= 10'd0;
            r_corr_value <= '0;
            r_acq_done   <= 1'b0;
            r_acq_found  <= 1'b0;
        end else begin
            r_acq_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (w_prn_ok) begin
                            r_tap_a      <= w_taps[7:4] - 4'd1;
                            r_tap_b      <= w_taps[3:0] - 4'd1;
                            r_threshold  <= threshold;
                            r_g1         <= 10'h3FF;
                            r_g2         <= 10'h3FF;
                            r_acc        <= '0;
                            r_chip_cnt   <= 10'd0;
                            r_phase      <= 10'd0;
                            r_peak       <= 11'd0;
                            r_code_phase <= 10'd0;
                            r_acq_found  <= 1'b0;
                            r_state      <= c_CORR;
                        end else begin
                            r_acq_done  <= 1'b1;
                            r_acq_found <= 1'b0;
                        end
                    end
                end
                c_CORR: begin
                    if (w_accept) begin
                        r_acc      <= w_acc_next;
                        r_g1       <= w_g1_next;
                        r_g2       <= w_g2_next;
                        r_chip_cnt <= r_chip_cnt + 10'd1;
                        if (r_chip_cnt == c_LAST_CHIP) begin
                            r_corr_value <= w_acc_next;
                            r_state      <= c_DUMP;
                        end
                    end
                end
                c_DUMP: begin
                    r_acc      <= '0;
                    r_chip_cnt <= 10'd0;
                    if (w_update) begin
                        r_peak       <= w_mag;
                        r_code_phase <= r_phase;
                    end
                    if ((r_phase == c_LAST_PHASE) || w_early) begin
                        r_acq_done  <= 1'b1;
                        r_acq_found <= (w_peak_next >= r_threshold);
                        r_state     <= c_DONE;
                    end else begin
                        r_state <= c_SLIP;
                    end
                end
                c_SLIP: begin
                    r_g1    <= w_g1_next;
                    r_g2    <= w_g2_next;
                    r_phase <= r_phase + 10'd1;
                    r_state <= c_CORR;
                end
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy       = (r_state != c_IDLE);
    assign corr_valid = (r_state == c_DUMP);
    assign corr_value = r_corr_value;
    assign acq_done   = r_acq_done;
    assign acq_found  = r_acq_found;
    assign code_phase = r_code_phase;
    assign peak_value = r_peak;

endmodule
`default_nettype wire

// File: tb/tb_cacode_acq_correlator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cacode_acq_correlator                                                   |
// | Self-checking bench: Gold-code sequence model, per-cycle output compare.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cacode_acq_correlator;
    localparam int NP     = 16;
    localparam int CW     = 12;
    localparam int L      = 1023;
    localparam int BUDGET = 40000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [5:0]           prn_num;
    logic [10:0]          threshold;
    logic                 start;
    logic                 chip_in;
    logic                 chip_in_valid;
    logic                 chip_in_ready;
    logic                 busy;
    logic                 corr_valid;
    logic signed [CW-1:0] corr_value;
    logic                 acq_done;
    logic                 acq_found;
    logic [9:0]           code_phase;
    logic [10:0]          peak_value;

    cacode_acq_correlator #(.NUM_PHASES(NP), .CORR_W(CW)) dut (
        .clk(clk), .rst(rst), .prn_num(prn_num), .threshold(threshold),
        .start(start), .chip_in(chip_in), .chip_in_valid(chip_in_valid),
        .chip_in_ready(chip_in_ready), .busy(busy), .corr_valid(corr_valid),
        .corr_value(corr_value), .acq_done(acq_done), .acq_found(acq_found),
        .code_phase(code_phase), .peak_value(peak_value)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // G1/G2 maximal-length sequences as seen at stage 10, one period each
    bit g1s [L+10];
    bit g2s [L+10];

    int exp_corr [NP];
    int exp_n, exp_peak, exp_phase;
    bit exp_found;
    bit src_inv, src_rnd;
    int idx;

    bit cmp_en = 1'b0;
    bit prev_acc, prev_cv, done_seen, exp_cv, exp_done;
    int n_acc, n_cv;
    int cv_hist [NP];

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic gen_msequences();
        for (int n = 0; n < 10; n++) begin
            g1s[n] = 1'b1;
            g2s[n] = 1'b1;
        end
        for (int n = 0; n < L; n++) begin
            g1s[n+10] = g1s[n] ^ g1s[n+7];
            g2s[n+10] = g2s[n] ^ g2s[n+1] ^ g2s[n+2] ^ g2s[n+4] ^ g2s[n+7] ^ g2s[n+8];
        end
    endtask

    // Stage j of G2 at chip k holds sequence element k+10-j
    function automatic bit ca_chip(input int ta, input int tb, input int k);
        return g1s[k] ^ g2s[(k + 10 - ta) % L] ^ g2s[(k + 10 - tb) % L];
    endfunction

    // Incoming stream: PRN1 code starting at its chip 5, optionally inverted
    function automatic bit src_chip(input int t);
        return ca_chip(2, 6, (t + 5) % L) ^ src_inv;
    endfunction

    task automatic build_model(input int ta, input int tb, input int thr, input bit inv);
        int s, mag;
        bit in_c, lc;
        src_inv   = inv;
        exp_n     = 0;
        exp_peak  = 0;
        exp_phase = 0;
        for (int p = 0; p < NP; p++) begin
            s = 0;
            for (int j = 0; j < L; j++) begin
                in_c = src_chip(p * L + j);
                lc   = ca_chip(ta, tb, (j + p) % L);
                s    = s + ((in_c == lc) ? 1 : -1);
            end
            exp_corr[p] = s;
            exp_n       = p + 1;
            mag         = (s < 0) ? -s : s;
            if (mag > exp_peak) begin
                exp_peak  = mag;
                exp_phase = p;
            end
`ifdef CACODE_ACQ_EARLY_EXIT_EN
            if (mag >= thr) begin
                exp_peak  = mag;
                exp_phase = p;
                break;
            end
`endif
        end
        exp_found = (exp_peak >= thr);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            exp_cv   = prev_acc && (n_acc > 0) && ((n_acc % L) == 0);
            exp_done = prev_cv && (n_cv == exp_n);
            check("corr_valid timing", corr_valid, exp_cv);
            check("acq_done timing", acq_done, exp_done);
            if (!done_seen) check("busy during search", busy, 1);
            if (corr_valid || prev_cv) check("ready in DUMP/SLIP", chip_in_ready, 0);
            if (corr_valid) begin
                if (n_cv < exp_n) begin
                    check("corr_value", corr_value, exp_corr[n_cv]);
                    cv_hist[n_cv] = int'(corr_value);
                end else begin
                    check("corr_valid count", n_cv + 1, exp_n);
                end
                n_cv++;
            end
            if (acq_done) begin
                check("acq_found", acq_found, exp_found);
                check("code_phase", code_phase, exp_phase);
                check("peak_value", peak_value, exp_peak);
                check("epochs reported", n_cv, exp_n);
                done_seen = 1'b1;
            end
            prev_acc = chip_in_valid && chip_in_ready;
            if (prev_acc) n_acc++;
            prev_cv = corr_valid;
        end
    end

    task automatic run_search(input logic [5:0] prn, input int thr, input bit rnd, input int abort_cyc);
        int  cyc;
        bit  acc_now;
        src_rnd   = rnd;
        n_acc     = 0;
        n_cv      = 0;
        prev_acc  = 1'b0;
        prev_cv   = 1'b0;
        done_seen = 1'b0;
        @(posedge clk);
        #1;
        prn_num       = prn;
        threshold     = 11'(thr);
        start         = 1'b1;
        idx           = 0;
        chip_in       = src_chip(0);
        chip_in_valid = src_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        cyc           = 0;
        while (!done_seen && (cyc < BUDGET) && ((abort_cyc == 0) || (cyc < abort_cyc))) begin
            @(negedge clk);
            acc_now = chip_in_valid && chip_in_ready;
            @(posedge clk);
            #1;
            if (cyc == 0) begin
                start  = 1'b0;
                cmp_en = 1'b1;
            end
            if (acc_now) idx++;
            chip_in       = src_chip(idx);
            chip_in_valid = src_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
        end
        cmp_en        = 1'b0;
        chip_in_valid = 1'b0;
        if (abort_cyc == 0) begin
            check("search finished in budget", done_seen, 1);
            check("chips consumed", idx, exp_n * L);
            check("busy after done", busy, 0);
        end
    endtask

    task automatic invalid_start(input logic [5:0] prn);
        @(posedge clk);
        #1;
        prn_num = prn;
        start   = 1'b1;
        @(negedge clk);
        check("busy before bad start", busy, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("bad prn acq_done", acq_done, 1);
        check("bad prn acq_found", acq_found, 0);
        check("bad prn busy", busy, 0);
        @(negedge clk);
        check("bad prn acq_done pulse width", acq_done, 0);
        check("bad prn busy later", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " ready"}, chip_in_ready, 0);
        check({tag, " corr_valid"}, corr_valid, 0);
        check({tag, " corr_value"}, corr_value, 0);
        check({tag, " acq_done"}, acq_done, 0);
        check({tag, " acq_found"}, acq_found, 0);
        check({tag, " code_phase"}, code_phase, 0);
        check({tag, " peak_value"}, peak_value, 0);
    endtask

    initial begin
        logic [9:0] first10;
        int         maxmag;
        rst           = 1'b1;
        start         = 1'b0;
        chip_in       = 1'b0;
        chip_in_valid = 1'b0;
        prn_num       = 6'd0;
        threshold     = 11'd0;
        src_inv       = 1'b0;
        src_rnd       = 1'b0;
        gen_msequences();
        #2;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // PRN1 begins 1440 octal
        for (int k = 0; k < 10; k++) first10[9-k] = ca_chip(2, 6, k);
        check("model PRN1 first chips", first10, 10'b1100100000);

        build_model(2, 6, 512, 1'b0);
        check("model aligned epoch", exp_corr[5], 1023);
        check("model peak", exp_peak, 1023);
        check("model phase", exp_phase, 5);
        check("model found", exp_found, 1);

        // Abort mid-CORR with an asynchronous reset, then run the same search again
        run_search(6'd1, 512, 1'b0, 1500);
        #3 rst = 1'b1;
        #1;
        check_all_zero("async reset");
        #12 rst = 1'b0;
        repeat (2) @(posedge clk);

        run_search(6'd1, 512, 1'b0, 0);
        check("PRN1 sixth corr_value", cv_hist[5], 1023);
        check("PRN1 code_phase held", code_phase, 5);
        check("PRN1 peak held", peak_value, 1023);
        check("PRN1 found held", acq_found, 1);

        invalid_start(6'd0);
        invalid_start(6'd38);

        build_model(2, 6, 512, 1'b1);
        check("model inverted epoch", exp_corr[5], -1023);
        run_search(6'd1, 512, 1'b1, 0);
        check("inverted sixth corr_value", cv_hist[5], -1023);
        check("inverted code_phase", code_phase, 5);
        check("inverted peak", peak_value, 1023);
        check("inverted found", acq_found, 1);

        build_model(1, 8, 512, 1'b0);
        maxmag = 0;
        for (int p = 0; p < exp_n; p++) begin
            if (exp_corr[p] > maxmag) maxmag = exp_corr[p];
            if (-exp_corr[p] > maxmag) maxmag = -exp_corr[p];
        end
        check("model cross-corr bound", (maxmag <= 65) ? 1 : 0, 1);
        check("model cross-corr found", exp_found, 0);
        run_search(6'd7, 512, 1'b0, 0);
        check("PRN7 not found", acq_found, 0);
        check("PRN7 peak bounded", (peak_value <= 11'd65) ? 1 : 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
